// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_pkg
// Brief    : Shared state encoding and divisor limits for clock_div_ctrl.
// Revision : 1.0
// ============================================================================
package clock_div_pkg;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_RUN    = 2'd1;
    localparam logic [1:0] C_SWITCH = 2'd2;

    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = C_IDLE,
        ST_RUN    = C_RUN,
        ST_SWITCH = C_SWITCH
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clock_div_counter.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_counter
// Brief    : Period counter 0..limit-1 with restart; exposes next count value.
// Revision : 1.0
// ============================================================================
module clock_div_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_limit,
    output logic [DIV_W-1:0] o_cnt,
    output logic [DIV_W-1:0] o_cnt_nxt,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;

    assign o_cnt     = r_cnt;
    assign o_tc      = (r_cnt == (i_limit - DIV_W'(1)));
    assign o_cnt_nxt = (i_restart || o_tc) ? '0 : (r_cnt + DIV_W'(1));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_ctrl
// Brief    : Programmable glitch-free clock divider; divisor and enable changes
//            land on period boundaries. Option macro: DUTY50_EN (50% odd duty).
// Revision : 1.0
// ============================================================================
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] active_div,
    output logic             busy,
    output logic             err_div
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] w_active_nxt;
    logic [DIV_W-1:0] r_pending;
    logic [DIV_W-1:0] w_pending_nxt;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_err;
    logic [DIV_W-1:0] w_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_tc;
    logic             w_accept;
    logic             w_legal;

    assign busy       = (r_state == ST_SWITCH);
    assign div_ready  = ~busy;
    assign active_div = r_active;
    assign tick       = r_tick;
    assign err_div    = r_err;
    assign w_accept   = div_valid & div_ready;
    assign w_legal    = (div_value >= DIV_W'(DIV_MIN));

    clock_div_counter #(
        .DIV_W (DIV_W)
    ) u_counter (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .i_restart (r_state == ST_IDLE),
        .i_limit   (r_active),
        .o_cnt     (w_cnt),
        .o_cnt_nxt (w_cnt_nxt),
        .o_tc      (w_tc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal) w_active_nxt = div_value;
                if (enable)              w_state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (w_tc) begin
                    if (w_accept && w_legal) w_active_nxt = div_value;
                    if (!enable)             w_state_nxt  = ST_IDLE;
                end else if (w_accept && w_legal) begin
                    w_pending_nxt = div_value;
                    w_state_nxt   = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (w_tc) begin
                    w_active_nxt = r_pending;
                    w_state_nxt  = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with cnt.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_active  <= DIV_W'(DEFAULT_DIV);
            r_pending <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_clk_out <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt < (w_active_nxt >> 1));
            r_tick    <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt == '0);
            r_err     <= w_accept && !w_legal;
        end
    end

`ifdef DUTY50_EN
    // Half-cycle delayed copy stretches the floor(N/2) high phase by 0.5 cycle for odd N.
    logic r_neg_q;

    always_ff @(negedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_clk_out;
        end
    end

    assign clk_out = r_clk_out | (r_neg_q & r_active[0]);
`else
    assign clk_out = r_clk_out;
`endif

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule
`default_nettype wire
